// File: rtl/beeb_pkg.sv
// Shared constants and types for the BBC Micro external bus cycle engine.
// Bus park values, the FE40 slowdown trigger and the bus state encoding.
package beeb_pkg;

  localparam logic [15:0] IDLE_AB    = 16'hFFFF;
  localparam logic [15:0] ADDR_FE40  = 16'hFE40;
  localparam logic [7:0]  IDLE_DO    = 8'hFF;
  localparam logic [7:0]  RD_RST     = 8'hFF;
  localparam int          SLOW_LONG  = 15;
  localparam int          SLOW_SHORT = 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } bus_state_e;

  // FE40 writes with a zero low field strobe the sound chip and
  // need the long hold-off; everything else only needs a short one.
  function automatic logic [3:0] slow_load(
    input logic [7:0] wdata,
    input int         lng,
    input int         sht
  );
    return (wdata[2:0] == 3'd0) ? 4'(lng) : 4'(sht);
  endfunction

endpackage

// File: rtl/beeb_bus_cycle_engine_if.sv
// CPU-side request/completion handshake of the Beeb bus cycle engine.
// master = request logic, slave = bus cycle engine.
interface beeb_bus_cycle_engine_if;

  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        req_done;
  logic [7:0]  rd_data;
  logic        slowdown_active;

  modport master (
    output req_valid,
    output req_addr,
    output req_we,
    output req_wdata,
    input  req_done,
    input  rd_data,
    input  slowdown_active
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_we,
    input  req_wdata,
    output req_done,
    output rd_data,
    output slowdown_active
  );

endinterface

// File: rtl/beeb_phi_sync.sv
// PhiIn delay chain in the cpu_clk domain; the first stages double as
// the synchroniser, later taps give Phi0 cycle boundaries.
module beeb_phi_sync
  import beeb_pkg::*;
#(
  parameter int NPHI0_REGS = 5,
  parameter int PHIOUT_TAP = 1
) (
  input  logic cpu_clk,
  input  logic Res_n,
  input  logic PhiIn,
  output logic phi2,
  output logic cyc_end,
  output logic cyc_start,
  output logic phi2_fall
);

  logic [NPHI0_REGS-1:0] phi0_r;

  always_ff @(posedge cpu_clk or negedge Res_n) begin
    if (!Res_n) begin
      phi0_r    <= '0;
      cyc_start <= 1'b0;
    end else begin
      phi0_r    <= {phi0_r[NPHI0_REGS-2:0], PhiIn};
      cyc_start <= cyc_end;
    end
  end

  // Older bit high, newer bit low: a falling Phi0 edge has arrived.
  assign cyc_end   = phi0_r[NPHI0_REGS-1]
                   & ~phi0_r[NPHI0_REGS-2];
  assign phi2_fall = phi0_r[PHIOUT_TAP+1]
                   & ~phi0_r[PHIOUT_TAP];
  assign phi2      = phi0_r[PHIOUT_TAP];

endmodule

// File: rtl/beeb_bus_cycle_engine.sv
// Runs one 6502-style motherboard bus cycle per CPU request, aligned to
// Phi0, and holds off new cycles during the post-FE40 slowdown window.
module beeb_bus_cycle_engine
  import beeb_pkg::ADDR_FE40;
  import beeb_pkg::IDLE_DO;
  import beeb_pkg::RD_RST;
  import beeb_pkg::bus_state_e;
  import beeb_pkg::IDLE;
  import beeb_pkg::ACTIVE;
  import beeb_pkg::slow_load;
#(
  parameter int          NPHI0_REGS = 5,
  parameter int          PHIOUT_TAP = 1,
  parameter int          SLOW_LONG  = beeb_pkg::SLOW_LONG,
  parameter int          SLOW_SHORT = beeb_pkg::SLOW_SHORT,
  parameter logic [15:0] IDLE_AB    = beeb_pkg::IDLE_AB
) (
  input  logic                          cpu_clk,
  input  logic                          Res_n,
  input  logic                          PhiIn,
  beeb_bus_cycle_engine_if.slave        req,
  output logic                          Phi1Out,
  output logic                          Phi2Out,
  output logic [15:0]                   beeb_AB,
  output logic                          beeb_WE,
  output logic [7:0]                    beeb_DO,
  output logic                          data_oe,
  input  logic [7:0]                    Data_in
);

  logic       phi2;
  logic       cyc_end;
  logic       cyc_start;
  logic       phi2_fall;

  bus_state_e state;
  bus_state_e state_nxt;
  logic [15:0] ab_nxt;
  logic        we_nxt;
  logic [7:0]  do_nxt;
  logic [7:0]  rd_q;
  logic [7:0]  rd_nxt;
  logic        done_q;
  logic        done_nxt;
  logic [3:0]  slow_cnt;
  logic [3:0]  slow_nxt;
  logic        fe40_wr;
  logic        can_start;

  beeb_phi_sync #(
    .NPHI0_REGS (NPHI0_REGS),
    .PHIOUT_TAP (PHIOUT_TAP)
  ) u_sync (
    .cpu_clk   (cpu_clk),
    .Res_n     (Res_n),
    .PhiIn     (PhiIn),
    .phi2      (phi2),
    .cyc_end   (cyc_end),
    .cyc_start (cyc_start),
    .phi2_fall (phi2_fall)
  );

  assign Phi2Out = phi2;
  assign Phi1Out = ~phi2;
  assign data_oe = beeb_WE & PhiIn;

  assign req.req_done        = done_q;
  assign req.rd_data         = rd_q;
  assign req.slowdown_active = (slow_cnt != 4'd0);

  assign fe40_wr   = (state == ACTIVE)
                   & beeb_WE
                   & (beeb_AB == ADDR_FE40);
  assign can_start = req.req_valid
                   & (slow_cnt == 4'd0);

  always_ff @(posedge cpu_clk or negedge Res_n) begin
    if (!Res_n) begin
      state    <= IDLE;
      beeb_AB  <= IDLE_AB;
      beeb_WE  <= 1'b0;
      beeb_DO  <= IDLE_DO;
      rd_q     <= RD_RST;
      done_q   <= 1'b0;
      slow_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      beeb_AB  <= ab_nxt;
      beeb_WE  <= we_nxt;
      beeb_DO  <= do_nxt;
      rd_q     <= rd_nxt;
      done_q   <= done_nxt;
      slow_cnt <= slow_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ab_nxt    = beeb_AB;
    we_nxt    = beeb_WE;
    do_nxt    = beeb_DO;
    rd_nxt    = rd_q;
    done_nxt  = 1'b0;
    slow_nxt  = slow_cnt;

    unique case (state)
      IDLE: begin
        if (cyc_start) begin
          if (can_start) begin
            state_nxt = ACTIVE;
            ab_nxt    = req.req_addr;
            we_nxt    = req.req_we;
            do_nxt    = req.req_wdata;
          end else begin
            ab_nxt    = IDLE_AB;
            we_nxt    = 1'b0;
            do_nxt    = IDLE_DO;
          end
        end
      end
      ACTIVE: begin
        if (phi2_fall && !beeb_WE) begin
          rd_nxt = Data_in;
        end
        // Bus stays driven past Phi2 fall until the next cyc_start.
        if (cyc_end) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase

    if (cyc_end) begin
      if (fe40_wr) begin
        slow_nxt = slow_load(beeb_DO, SLOW_LONG, SLOW_SHORT);
      end else if (slow_cnt != 4'd0) begin
        slow_nxt = slow_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_beeb_bus_cycle_engine.sv
// Bench for beeb_bus_cycle_engine: directed table, corner sequences and
// random traffic checked against a Phi0-period-level reference model.
module tb_beeb_bus_cycle_engine;

  logic        cpu_clk;
  logic        Res_n;
  logic        PhiIn;
  logic        Phi1Out;
  logic        Phi2Out;
  logic [15:0] beeb_AB;
  logic        beeb_WE;
  logic [7:0]  beeb_DO;
  logic        data_oe;
  logic [7:0]  Data_in;

  beeb_bus_cycle_engine_if bus ();

  beeb_bus_cycle_engine u_dut (
    .cpu_clk (cpu_clk),
    .Res_n   (Res_n),
    .PhiIn   (PhiIn),
    .req     (bus),
    .Phi1Out (Phi1Out),
    .Phi2Out (Phi2Out),
    .beeb_AB (beeb_AB),
    .beeb_WE (beeb_WE),
    .beeb_DO (beeb_DO),
    .data_oe (data_oe),
    .Data_in (Data_in)
  );

  // cpu_clk period 10, Phi0 period 400: the 80 MHz / 2 MHz ratio,
  // with Phi0 edges offset so they never coincide with cpu_clk edges.
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    PhiIn = 1'b0;
    #3;
    forever #200 PhiIn = ~PhiIn;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference model state, in units of Phi0 periods.
  int          phi_falls = 0;
  int          slow_end  = 0;
  logic [7:0]  model_rd  = 8'hFF;
  logic [7:0]  dat [256];
  bit          din_fixed_en = 1'b0;
  logic [7:0]  din_fixed    = 8'h00;
  bit          mon_en   = 1'b0;
  bit          act_valid = 1'b0;
  int          act_start = 0;
  logic [15:0] act_addr;
  logic        act_we;
  logic [7:0]  act_wd;
  int          done_seen = 0;
  int          exp_dones = 0;
  logic        prev_done = 1'b0;

  always @(negedge PhiIn) begin
    phi_falls++;
    #1;
    if (mon_en) chk("oe_low", 32'(data_oe), 32'd0);
  end

  always @(posedge PhiIn) begin
    #40;
    Data_in = din_fixed_en ? din_fixed : dat[8'(phi_falls)];
  end

  // Mid-Phi2 view: either the owned cycle of this period, or parked.
  always @(posedge PhiIn) begin
    #1;
    if (mon_en) begin
      if (act_valid && phi_falls == act_start) begin
        chk("mon_ab", 32'(beeb_AB), 32'(act_addr));
        chk("mon_we", 32'(beeb_WE), 32'(act_we));
        chk("mon_do", 32'(beeb_DO), 32'(act_wd));
        chk("mon_oe", 32'(data_oe), 32'(act_we));
      end else begin
        chk("park_ab", 32'(beeb_AB), 32'hFFFF);
        chk("park_we", 32'(beeb_WE), 32'd0);
        chk("park_do", 32'(beeb_DO), 32'hFF);
      end
      chk("slow_act", 32'(bus.slowdown_active),
          32'(phi_falls < slow_end));
    end
  end

  always @(negedge cpu_clk) begin
    if (bus.req_done) begin
      done_seen++;
      chk("done_width", 32'(prev_done), 32'd0);
    end
    prev_done = bus.req_done;
  end

  task automatic do_txn(
    input logic [15:0] a,
    input logic        w,
    input logic [7:0]  d,
    input bit          b2b
  );
    int first;
    int start;
    int waited;
    bit ok;
    first = b2b ? phi_falls : phi_falls + 1;
    start = (first > slow_end) ? first : slow_end;
    act_addr  = a;
    act_we    = w;
    act_wd    = d;
    act_start = start;
    act_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = w;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited < 4000) begin
      @(negedge cpu_clk);
      waited++;
      if (bus.req_done) ok = 1'b1;
    end
    bus.req_valid = 1'b0;
    act_valid     = 1'b0;
    chk("done_seen", 32'(ok), 32'd1);
    if (ok) begin
      exp_dones++;
      chk("latency", 32'(phi_falls), 32'(start + 1));
      if (w && a == 16'hFE40)
        slow_end = start + 1 + ((d[2:0] == 3'd0) ? 15 : 1);
      if (!w)
        model_rd = din_fixed_en ? din_fixed : dat[8'(start)];
      chk("rd_model", 32'(bus.rd_data), 32'(model_rd));
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic        b2b;
    logic [7:0]  exp_rd;
    logic        exp_slow;
  } vec_t;

  localparam int NV = 11;
  vec_t tv [NV];

  initial begin
    int n;
    logic [15:0] ra;
    logic        rw;
    logic [7:0]  rd;
    bit          rb;

    tv[0]  = '{16'hFE4D, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b0};
    tv[1]  = '{16'h3000, 1'b1, 8'hA5, 8'h11, 1'b1, 8'h5A, 1'b0};
    tv[2]  = '{16'hFE40, 1'b1, 8'h08, 8'h22, 1'b1, 8'h5A, 1'b1};
    tv[3]  = '{16'h1234, 1'b0, 8'h00, 8'hC3, 1'b1, 8'hC3, 1'b0};
    tv[4]  = '{16'hFE40, 1'b1, 8'h0B, 8'h44, 1'b1, 8'hC3, 1'b1};
    tv[5]  = '{16'hFE40, 1'b1, 8'h0B, 8'h55, 1'b1, 8'hC3, 1'b1};
    tv[6]  = '{16'h8000, 1'b0, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0};
    tv[7]  = '{16'hFE40, 1'b1, 8'h00, 8'h66, 1'b1, 8'h3C, 1'b1};
    tv[8]  = '{16'hFE41, 1'b1, 8'h00, 8'h99, 1'b0, 8'h3C, 1'b0};
    tv[9]  = '{16'hFE40, 1'b0, 8'h00, 8'h77, 1'b1, 8'h77, 1'b0};
    tv[10] = '{16'hFE40, 1'b1, 8'hF8, 8'h88, 1'b1, 8'h77, 1'b1};

    for (int i = 0; i < 256; i++) dat[i] = 8'($urandom);

    Res_n         = 1'b0;
    Data_in       = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_we    = 1'b0;
    bus.req_wdata = 8'h00;

    #100;
    chk("rst_ab",   32'(beeb_AB), 32'hFFFF);
    chk("rst_we",   32'(beeb_WE), 32'd0);
    chk("rst_do",   32'(beeb_DO), 32'hFF);
    chk("rst_rd",   32'(bus.rd_data), 32'hFF);
    chk("rst_done", 32'(bus.req_done), 32'd0);
    chk("rst_slow", 32'(bus.slowdown_active), 32'd0);
    chk("rst_phi2", 32'(Phi2Out), 32'd0);
    chk("rst_phi1", 32'(Phi1Out), 32'd1);
    chk("rst_oe",   32'(data_oe), 32'd0);

    @(posedge PhiIn);
    #20;
    Res_n  = 1'b1;
    mon_en = 1'b1;

    @(posedge PhiIn);
    #80;
    chk("phi2_hi", 32'(Phi2Out), 32'd1);
    chk("phi1_lo", 32'(Phi1Out), 32'd0);
    @(negedge PhiIn);
    #80;
    chk("phi2_lo", 32'(Phi2Out), 32'd0);
    chk("phi1_hi", 32'(Phi1Out), 32'd1);

    din_fixed_en = 1'b1;
    for (int i = 0; i < NV; i++) begin
      din_fixed = tv[i].din;
      if (!tv[i].b2b) begin
        @(posedge PhiIn);
        #60;
      end
      do_txn(tv[i].addr, tv[i].we, tv[i].wd, tv[i].b2b);
      chk("tv_rd", 32'(bus.rd_data), 32'(tv[i].exp_rd));
      chk("tv_slow", 32'(bus.slowdown_active),
          32'(tv[i].exp_slow));
    end
    din_fixed_en = 1'b0;

    // Write address/data hold until the next cyc_start, then park.
    while (phi_falls < slow_end) @(posedge PhiIn);
    @(posedge PhiIn);
    #60;
    do_txn(16'h3000, 1'b1, 8'hA5, 1'b0);
    chk("hold_ab", 32'(beeb_AB), 32'h3000);
    chk("hold_we", 32'(beeb_WE), 32'd1);
    chk("hold_do", 32'(beeb_DO), 32'hA5);
    @(negedge cpu_clk);
    chk("idle_ab", 32'(beeb_AB), 32'hFFFF);
    chk("idle_we", 32'(beeb_WE), 32'd0);
    chk("idle_do", 32'(beeb_DO), 32'hFF);

    // Request arriving one cpu_clk after cyc_start.
    n = 0;
    while (!u_dut.cyc_start && n < 200) begin
      @(negedge cpu_clk);
      n++;
    end
    chk("late_sync", 32'(n < 200), 32'd1);
    @(negedge cpu_clk);
    do_txn(16'h5555, 1'b0, 8'h00, 1'b0);

    // Reset during slowdown clears the counter immediately.
    @(posedge PhiIn);
    #60;
    do_txn(16'hFE40, 1'b1, 8'h10, 1'b0);
    repeat (3) @(posedge PhiIn);
    #20;
    mon_en = 1'b0;
    Res_n  = 1'b0;
    #1;
    chk("rs_slow", 32'(bus.slowdown_active), 32'd0);
    chk("rs_ab",   32'(beeb_AB), 32'hFFFF);
    #30;
    Res_n    = 1'b1;
    slow_end = 0;
    model_rd = 8'hFF;
    mon_en   = 1'b1;
    do_txn(16'h4000, 1'b0, 8'h00, 1'b0);

    // Reset while a cycle is on the bus.
    @(posedge PhiIn);
    #60;
    mon_en        = 1'b0;
    bus.req_addr  = 16'h2000;
    bus.req_we    = 1'b1;
    bus.req_wdata = 8'h3C;
    bus.req_valid = 1'b1;
    n = 0;
    while (beeb_AB != 16'h2000 && n < 200) begin
      @(negedge cpu_clk);
      n++;
    end
    chk("ra_start", 32'(beeb_AB), 32'h2000);
    Res_n = 1'b0;
    #1;
    chk("ra_ab",   32'(beeb_AB), 32'hFFFF);
    chk("ra_we",   32'(beeb_WE), 32'd0);
    chk("ra_do",   32'(beeb_DO), 32'hFF);
    chk("ra_done", 32'(bus.req_done), 32'd0);
    chk("ra_rd",   32'(bus.rd_data), 32'hFF);
    chk("ra_oe",   32'(data_oe), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge PhiIn);
    #20;
    Res_n    = 1'b1;
    slow_end = 0;
    model_rd = 8'hFF;
    mon_en   = 1'b1;
    do_txn(16'h2000, 1'b1, 8'h3C, 1'b0);

    // Random traffic against the period-level model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        ra = 16'hFE40;
        rw = 1'b1;
        rd = $urandom_range(0, 1) ? {5'($urandom), 3'b000}
                                  : 8'($urandom);
      end else begin
        ra = 16'($urandom);
        rw = 1'($urandom_range(0, 1));
        rd = 8'($urandom);
      end
      rb = ($urandom_range(0, 9) < 3);
      if (!rb) begin
        repeat ($urandom_range(0, 2)) @(posedge PhiIn);
        @(posedge PhiIn);
        #($urandom_range(10, 150));
      end
      do_txn(ra, rw, rd, rb);
    end

    repeat (3) @(posedge PhiIn);
    chk("done_count", 32'(done_seen), 32'(exp_dones));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
